// File: rtl/alu_dispatch_if.sv
// Request and dispatch channel bundle for alu_dispatch.
// The slave modport is the dispatcher side; the master modport is the requester and unit side.
interface alu_dispatch_if #(
    parameter int unsigned WL   = 32,
    parameter int unsigned OPW  = 4,
    parameter int unsigned TAGW = 4,
    parameter int unsigned CNTW = 16
) ();
    logic            in_valid;
    logic            in_ready;
    logic            in_sel;
    logic [OPW-1:0]  in_op;
    logic [WL-1:0]   in_a;
    logic [WL-1:0]   in_b;

    logic            ar_valid;
    logic            ar_ready;
    logic [OPW-1:0]  ar_op;
    logic [WL-1:0]   ar_a;
    logic [WL-1:0]   ar_b;
    logic [TAGW-1:0] ar_tag;

    logic            lg_valid;
    logic            lg_ready;
    logic [OPW-1:0]  lg_op;
    logic [WL-1:0]   lg_a;
    logic [WL-1:0]   lg_b;
    logic [TAGW-1:0] lg_tag;

    logic [CNTW-1:0] ar_count;
    logic [CNTW-1:0] lg_count;

    modport master (
        output in_valid, in_sel, in_op, in_a, in_b, ar_ready, lg_ready,
        input  in_ready,
        input  ar_valid, ar_op, ar_a, ar_b, ar_tag,
        input  lg_valid, lg_op, lg_a, lg_b, lg_tag,
        input  ar_count, lg_count
    );

    modport slave (
        input  in_valid, in_sel, in_op, in_a, in_b, ar_ready, lg_ready,
        output in_ready,
        output ar_valid, ar_op, ar_a, ar_b, ar_tag,
        output lg_valid, lg_op, lg_a, lg_b, lg_tag,
        output ar_count, lg_count
    );
endinterface

// File: rtl/alu_dispatch.sv
// Routes one request per cycle into a one-entry arithmetic or logic slot,
// stamping a wrapping sequence tag and counting dispatches per unit.
module alu_dispatch #(
    parameter int unsigned WL   = 32,
    parameter int unsigned OPW  = 4,
    parameter int unsigned TAGW = 4,
    parameter int unsigned CNTW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_dispatch_if.slave bus
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [WL-1:0]   a;
        logic [WL-1:0]   b;
        logic [TAGW-1:0] tag;
    } slot_t;

    slot_state_e     ar_state_q, ar_state_d;
    slot_state_e     lg_state_q, lg_state_d;
    slot_t           ar_slot_q, ar_slot_d;
    slot_t           lg_slot_q, lg_slot_d;
    slot_t           req_c;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [CNTW-1:0] ar_cnt_q, ar_cnt_d;
    logic [CNTW-1:0] lg_cnt_q, lg_cnt_d;

    logic ar_free_c, lg_free_c;
    logic ar_drain_c, lg_drain_c;
    logic accept_c, ar_acc_c, lg_acc_c;

    // A slot can take a new request if it is empty or draining this cycle.
    assign ar_drain_c = (ar_state_q == S_FULL) & bus.ar_ready;
    assign lg_drain_c = (lg_state_q == S_FULL) & bus.lg_ready;
    assign ar_free_c  = (ar_state_q == S_EMPTY) | bus.ar_ready;
    assign lg_free_c  = (lg_state_q == S_EMPTY) | bus.lg_ready;

    assign bus.in_ready = bus.in_sel ? lg_free_c : ar_free_c;
    assign accept_c     = bus.in_valid & bus.in_ready;
    assign ar_acc_c     = accept_c & ~bus.in_sel;
    assign lg_acc_c     = accept_c & bus.in_sel;

    assign req_c = '{op: bus.in_op, a: bus.in_a, b: bus.in_b, tag: tag_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_state_q <= S_EMPTY;
            lg_state_q <= S_EMPTY;
            ar_slot_q  <= '0;
            lg_slot_q  <= '0;
            tag_q      <= '0;
            ar_cnt_q   <= '0;
            lg_cnt_q   <= '0;
        end else begin
            ar_state_q <= ar_state_d;
            lg_state_q <= lg_state_d;
            ar_slot_q  <= ar_slot_d;
            lg_slot_q  <= lg_slot_d;
            tag_q      <= tag_d;
            ar_cnt_q   <= ar_cnt_d;
            lg_cnt_q   <= lg_cnt_d;
        end
    end

    always_comb begin
        ar_state_d = ar_state_q;
        lg_state_d = lg_state_q;
        ar_slot_d  = ar_slot_q;
        lg_slot_d  = lg_slot_q;
        tag_d      = tag_q;
        ar_cnt_d   = ar_cnt_q;
        lg_cnt_d   = lg_cnt_q;

        case (ar_state_q)
            S_EMPTY: if (ar_acc_c) ar_state_d = S_FULL;
            S_FULL:  if (!ar_acc_c && ar_drain_c) ar_state_d = S_EMPTY;
            default: ar_state_d = S_EMPTY;
        endcase

        case (lg_state_q)
            S_EMPTY: if (lg_acc_c) lg_state_d = S_FULL;
            S_FULL:  if (!lg_acc_c && lg_drain_c) lg_state_d = S_EMPTY;
            default: lg_state_d = S_EMPTY;
        endcase

        if (ar_acc_c) ar_slot_d = req_c;
        if (lg_acc_c) lg_slot_d = req_c;

        if (accept_c) tag_d = tag_q + TAGW'(1);

        // Counters stick at all-ones rather than wrapping.
        if (ar_acc_c && (ar_cnt_q != '1)) ar_cnt_d = ar_cnt_q + CNTW'(1);
        if (lg_acc_c && (lg_cnt_q != '1)) lg_cnt_d = lg_cnt_q + CNTW'(1);
    end

    assign bus.ar_valid = (ar_state_q == S_FULL);
    assign bus.ar_op    = ar_slot_q.op;
    assign bus.ar_a     = ar_slot_q.a;
    assign bus.ar_b     = ar_slot_q.b;
    assign bus.ar_tag   = ar_slot_q.tag;

    assign bus.lg_valid = (lg_state_q == S_FULL);
    assign bus.lg_op    = lg_slot_q.op;
    assign bus.lg_a     = lg_slot_q.a;
    assign bus.lg_b     = lg_slot_q.b;
    assign bus.lg_tag   = lg_slot_q.tag;

    assign bus.ar_count = ar_cnt_q;
    assign bus.lg_count = lg_cnt_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized and directed bench for alu_dispatch against a queue-based reference model.
// A second instance with 2-bit counters exercises counter saturation on the same stimulus.
module tb_alu_dispatch;

    localparam int unsigned WL   = 32;
    localparam int unsigned OPW  = 4;
    localparam int unsigned TAGW = 4;
    localparam int unsigned CNTW = 16;
    localparam int unsigned CNTS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           in_valid = 1'b0;
    logic           in_sel = 1'b0;
    logic [OPW-1:0] in_op = '0;
    logic [WL-1:0]  in_a = '0;
    logic [WL-1:0]  in_b = '0;
    logic           ar_ready = 1'b0;
    logic           lg_ready = 1'b0;

    alu_dispatch_if #(.WL(WL), .OPW(OPW), .TAGW(TAGW), .CNTW(CNTW)) bus ();
    alu_dispatch_if #(.WL(WL), .OPW(OPW), .TAGW(TAGW), .CNTW(CNTS)) bus_s ();

    assign bus.in_valid   = in_valid;
    assign bus.in_sel     = in_sel;
    assign bus.in_op      = in_op;
    assign bus.in_a       = in_a;
    assign bus.in_b       = in_b;
    assign bus.ar_ready   = ar_ready;
    assign bus.lg_ready   = lg_ready;
    assign bus_s.in_valid = in_valid;
    assign bus_s.in_sel   = in_sel;
    assign bus_s.in_op    = in_op;
    assign bus_s.in_a     = in_a;
    assign bus_s.in_b     = in_b;
    assign bus_s.ar_ready = ar_ready;
    assign bus_s.lg_ready = lg_ready;

    alu_dispatch #(.WL(WL), .OPW(OPW), .TAGW(TAGW), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alu_dispatch #(.WL(WL), .OPW(OPW), .TAGW(TAGW), .CNTW(CNTS)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    // Reference model: each slot is a queue holding at most one request.
    typedef struct {
        logic [OPW-1:0]  op;
        logic [WL-1:0]   a;
        logic [WL-1:0]   b;
        logic [TAGW-1:0] tag;
    } req_t;

    req_t ar_m[$];
    req_t lg_m[$];
    int   tag_m;
    int   ar_cnt_m;
    int   lg_cnt_m;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int c, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    function automatic logic exp_ready();
        if (in_sel) return (lg_m.size() == 0) || lg_ready;
        return (ar_m.size() == 0) || ar_ready;
    endfunction

    task automatic model_reset();
        ar_m.delete();
        lg_m.delete();
        tag_m    = 0;
        ar_cnt_m = 0;
        lg_cnt_m = 0;
    endtask

    task automatic compare_all();
        check("in_ready", 64'(bus.in_ready), 64'(exp_ready()));
        check("ar_valid", 64'(bus.ar_valid), 64'(ar_m.size() != 0));
        check("lg_valid", 64'(bus.lg_valid), 64'(lg_m.size() != 0));
        if (ar_m.size() != 0) begin
            check("ar_op",  64'(bus.ar_op),  64'(ar_m[0].op));
            check("ar_a",   64'(bus.ar_a),   64'(ar_m[0].a));
            check("ar_b",   64'(bus.ar_b),   64'(ar_m[0].b));
            check("ar_tag", 64'(bus.ar_tag), 64'(ar_m[0].tag));
        end
        if (lg_m.size() != 0) begin
            check("lg_op",  64'(bus.lg_op),  64'(lg_m[0].op));
            check("lg_a",   64'(bus.lg_a),   64'(lg_m[0].a));
            check("lg_b",   64'(bus.lg_b),   64'(lg_m[0].b));
            check("lg_tag", 64'(bus.lg_tag), 64'(lg_m[0].tag));
        end
        check("ar_count",     64'(bus.ar_count),   64'(sat(ar_cnt_m, CNTW)));
        check("lg_count",     64'(bus.lg_count),   64'(sat(lg_cnt_m, CNTW)));
        check("sat_in_ready", 64'(bus_s.in_ready), 64'(exp_ready()));
        check("sat_ar_count", 64'(bus_s.ar_count), 64'(sat(ar_cnt_m, CNTS)));
        check("sat_lg_count", 64'(bus_s.lg_count), 64'(sat(lg_cnt_m, CNTS)));
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic cycle(input logic v, input logic s, input logic [OPW-1:0] op,
                         input logic [WL-1:0] a, input logic [WL-1:0] b,
                         input logic arr, input logic lgr);
        logic acc;
        req_t r;
        in_valid = v; in_sel = s; in_op = op; in_a = a; in_b = b;
        ar_ready = arr; lg_ready = lgr;
        #1;
        compare_all();
        acc = v && exp_ready();
        r.op = op; r.a = a; r.b = b; r.tag = TAGW'(tag_m);
        @(posedge clk);
        if (ar_m.size() != 0 && arr) void'(ar_m.pop_front());
        if (lg_m.size() != 0 && lgr) void'(lg_m.pop_front());
        if (acc) begin
            if (s) begin lg_m.push_back(r); lg_cnt_m++; end
            else   begin ar_m.push_back(r); ar_cnt_m++; end
            tag_m = (tag_m + 1) % (1 << TAGW);
        end
        @(negedge clk);
    endtask

    task automatic rand_cycle();
        cycle($urandom_range(0, 3) != 0, 1'($urandom), OPW'($urandom), $urandom, $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    endtask

    // Asserts reset between edges and checks it acts without a clock.
    task automatic apply_reset();
        #2;
        rst_n    = 1'b0;
        in_valid = 1'($urandom); in_sel = 1'($urandom); in_op = OPW'($urandom);
        in_a     = $urandom;     in_b = $urandom;
        ar_ready = 1'($urandom); lg_ready = 1'($urandom);
        #1;
        model_reset();
        compare_all();
        check("rst_ar_tag", 64'(bus.ar_tag), 64'd0);
        check("rst_lg_tag", 64'(bus.lg_tag), 64'd0);
        check("rst_ar_a",   64'(bus.ar_a),   64'd0);
        check("rst_lg_b",   64'(bus.lg_b),   64'd0);
        check("rst_ar_op",  64'(bus.ar_op),  64'd0);
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        apply_reset();

        // First post-reset request: sign bits pass through untouched.
        cycle(1'b1, 1'b0, 4'd3, 32'hFFFF_FFFB, 32'd7, 1'b0, 1'b0);
        check("first_ar_valid", 64'(bus.ar_valid), 64'd1);
        check("first_ar_a",     64'(bus.ar_a),     64'hFFFF_FFFB);
        check("first_ar_b",     64'(bus.ar_b),     64'd7);
        check("first_ar_tag",   64'(bus.ar_tag),   64'd0);
        check("first_ar_count", 64'(bus.ar_count), 64'd1);

        // Stalled arithmetic slot blocks only arithmetic requests.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'($urandom), $urandom, $urandom, 1'b0, 1'b0);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        cycle(1'b1, 1'b1, 4'd9, 32'h1234_5678, 32'h0BAD_F00D, 1'b0, 1'b0);
        check("bp_lg_tag", 64'(bus.lg_tag), 64'd1);
        check("bp_ar_a",   64'(bus.ar_a),   64'hFFFF_FFFB);

        // Full-rate drain, continuing past the tag wrap.
        @(negedge clk);
        apply_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'(i), 32'(i * 3), 32'(-i), 1'b1, 1'b1);
        check("tp_ar_count", 64'(bus.ar_count), 64'd8);
        for (int i = 8; i < 17; i++) cycle(1'b1, 1'b0, 4'(i), 32'(i), 32'(i), 1'b1, 1'b1);
        check("wrap_ar_tag", 64'(bus.ar_tag), 64'd0);
        cycle(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);

        // Saturation on the narrow-counter instance.
        @(negedge clk);
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 4'(i), $urandom, $urandom, 1'b1, 1'b1);
        check("sat_lg_count_final", 64'(bus_s.lg_count), 64'd3);
        check("sat_ar_count_final", 64'(bus_s.ar_count), 64'd0);

        // Alternate channels into stalled slots, then reset mid-flight.
        cycle(1'b1, 1'b0, 4'd1, 32'hAAAA_0001, 32'd1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'd2, 32'h5555_0002, 32'd2, 1'b0, 1'b0);
        check("alt_ar_valid", 64'(bus.ar_valid), 64'd1);
        check("alt_lg_valid", 64'(bus.lg_valid), 64'd1);
        apply_reset();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) apply_reset();
            else rand_cycle();
        end
        cycle(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Registered request dispatcher in front of the datapath's arithmetic and logic units. Accepts one operation per cycle on a valid/ready input channel and routes it by a 1-bit unit select to one of two registered output channels, arithmetic (select 0) or logic (select 1). Each accepted request carries a wrapping sequence tag so results can be re-ordered downstream of the result mux. Two saturating counters track how many operations went to each unit.

## Interface
- WL, 32, operand width in bits
- OPW, 4, opcode width in bits
- TAGW, 4, sequence tag width in bits
- CNTW, 16, dispatch counter width in bits

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted this cycle when high with in_valid
- in_sel  in  1  unit select: 0 = arithmetic, 1 = logic
- in_op  in  OPW  unit opcode
- in_a, in_b  in  WL each  signed operands
- ar_valid  out  1  arithmetic channel holds a request
- ar_ready  in  1  arithmetic unit consumes when high with ar_valid
- ar_op / ar_a / ar_b / ar_tag  out  OPW / WL / WL / TAGW  arithmetic payload
- lg_valid  out  1  logic channel holds a request
- lg_ready  in  1  logic unit consumes when high with lg_valid
- lg_op / lg_a / lg_b / lg_tag  out  OPW / WL / WL / TAGW  logic payload
- ar_count, lg_count  out  CNTW each  saturating number of requests accepted per channel

## Operation
- Each output channel is a one-entry slot with states EMPTY (valid 0) and FULL (valid 1).
- Slot transitions: EMPTY + accept-for-this-slot -> FULL; FULL + drain (valid & ready) without accept -> EMPTY; FULL + drain + accept -> FULL with new payload; FULL, no drain -> FULL, payload held.
- in_ready = (in_sel ? (!lg_valid | lg_ready) : (!ar_valid | ar_ready)). It depends on in_sel and the selected slot only, never on in_valid. A full, stalled slot does not block requests to the other slot.
- Accept = in_valid & in_ready. On accept, in_op, in_a, in_b, and the current tag are captured into the selected slot. The unselected slot is untouched.
- The tag register starts at 0 and increments by 1 on every accept regardless of channel. It wraps from 2^TAGW-1 to 0.
- On accept, the selected channel's counter increments by 1. At all-ones it stays at all-ones (saturates, no wrap).
- Operands pass through bit-exact; no sign extension or arithmetic is performed.

## Timing
- Reset (rst_n low, asynchronous): ar_valid = lg_valid = 0; all payload outputs 0; tag 0; ar_count = lg_count = 0. in_ready is therefore 1 for either select while in reset and afterwards.
- Deassertion of rst_n takes effect at the next clk edge. A request presented in the first post-reset cycle is accepted.
- Latency: accept at edge N gives channel valid plus payload visible after edge N. Consumption is possible at edge N+1.
- Throughput: 1 request/cycle into a channel whose consumer holds ready high continuously.
- While valid & !ready, payload and tag are stable until the drain edge.
- Reset asserted mid-operation: pending slot contents are discarded immediately; nothing is replayed.
- Back-to-back requests alternating channels: both slots fill on successive cycles with consecutive tags.

## Test plan
- Reset: hold rst_n = 0 with random inputs -> ar_valid = lg_valid = 0, counters 0, in_ready = 1. Release, send sel = 0, op = 3, a = -5, b = 7 -> next cycle ar_valid = 1, ar_a = 32'hFFFFFFFB, ar_b = 7, ar_tag = 0, ar_count = 1.
- Backpressure: fill the arithmetic slot with ar_ready = 0, then offer sel = 0 -> in_ready = 0 and payload is stable for 5 cycles. Offer sel = 1 in the same window -> accepted, lg_valid next cycle, lg_tag = 1.
- Full-throughput drain: ar_ready = 1, 8 consecutive sel = 0 requests -> in_ready stays 1, ar_valid high for 8 cycles, tags 0..7 in order, ar_count = 8.
- Tag wrap: issue 17 accepts with TAGW = 4 -> the 17th request carries tag 0.
- Counter saturation with CNTW = 2: 5 logic accepts -> lg_count reads 1, 2, 3, 3, 3; ar_count stays 0.
- Asynchronous reset mid-flight: both slots full and stalled; pulse rst_n low between clock edges -> ar_valid and lg_valid drop without waiting for a clock edge, tag and counters return to 0.
